// File: rtl/sr_latch_driver_pkg.sv
// Shared types and defaults for the SR latch driver: FSM state encoding and
// default debounce/pulse timing.
package sr_latch_driver_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PULSE_SET = 2'b01,
    PULSE_RST = 2'b10,
    GAP       = 2'b11
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_PULSE_LEN       = 2;
  localparam int DEFAULT_CNT_W           = 8;

  function automatic logic state_is_busy(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and a
// one-cycle request on each rising edge of the debounced level.
module sr_debounce
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_req
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff = r_sync2 ^ r_level;

  // The level flips on the first differing sample after DEBOUNCE_CYCLES
  // differing samples have been counted, i.e. DEBOUNCE_CYCLES+1 in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LIMIT) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_req = r_level & ~r_level_d;

endmodule

// File: rtl/sr_latch_driver.sv
// Debounced, mutually exclusive set/reset pulse generator for an SR latch.
// Optional macro SR_LATCH_DRIVER_SKIP_REDUNDANT_EN drops requests that match state_q.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PULSE_LEN       = DEFAULT_PULSE_LEN,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic set_in,
  input  logic reset_in,
  output logic set_out,
  output logic reset_out,
  output logic busy,
  output logic state_q
);

  localparam logic [CNT_W-1:0] LP_PULSE_LAST  = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] LP_PULSE_FIRST = CNT_W'(1);

  state_t           r_state;
  logic             r_pend_set;
  logic             r_pend_rst;
  logic [CNT_W-1:0] r_pcnt;
  logic             r_set_out;
  logic             r_reset_out;
  logic             r_busy;
  logic             r_state_q;

  logic w_set_req;
  logic w_rst_req;
  logic w_want_set;
  logic w_want_rst;
  logic w_take_set;
  logic w_take_rst;
  logic w_pend_set_nxt;
  logic w_pend_rst_nxt;
  logic w_pulse_done;

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_set (
    .clk  (clk),
    .reset(reset),
    .i_raw(set_in),
    .o_req(w_set_req)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_rst (
    .clk  (clk),
    .reset(reset),
    .i_raw(reset_in),
    .o_req(w_rst_req)
  );

  assign w_want_set = w_set_req | r_pend_set;
  assign w_want_rst = w_rst_req | r_pend_rst;

`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
  assign w_take_rst = w_want_rst & r_state_q;
  assign w_take_set = w_want_set & ~r_state_q;
`else
  assign w_take_rst = w_want_rst;
  assign w_take_set = w_want_set;
`endif

  // While busy, requests collapse into one-deep per-direction flags.
  assign w_pend_set_nxt = r_pend_set | w_set_req;
  assign w_pend_rst_nxt = r_pend_rst | w_rst_req;
  assign w_pulse_done   = (r_pcnt == LP_PULSE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pend_set  <= 1'b0;
      r_pend_rst  <= 1'b0;
      r_pcnt      <= '0;
      r_set_out   <= 1'b0;
      r_reset_out <= 1'b0;
      r_busy      <= 1'b0;
      r_state_q   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pend_set <= 1'b0;
          r_pend_rst <= 1'b0;
          r_pcnt     <= LP_PULSE_FIRST;
          if (w_take_rst) begin
            // Reset wins; a coincident or pending set waits its turn.
            r_state     <= PULSE_RST;
            r_reset_out <= 1'b1;
            r_busy      <= 1'b1;
            r_state_q   <= 1'b0;
            r_pend_set  <= w_want_set;
          end else if (w_take_set) begin
            r_state   <= PULSE_SET;
            r_set_out <= 1'b1;
            r_busy    <= 1'b1;
            r_state_q <= 1'b1;
          end
        end
        PULSE_SET, PULSE_RST: begin
          r_pend_set <= w_pend_set_nxt;
          r_pend_rst <= w_pend_rst_nxt;
          if (w_pulse_done) begin
            r_state     <= GAP;
            r_set_out   <= 1'b0;
            r_reset_out <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        GAP: begin
          r_pend_set <= w_pend_set_nxt;
          r_pend_rst <= w_pend_rst_nxt;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_set_out   <= 1'b0;
          r_reset_out <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign set_out   = r_set_out;
  assign reset_out = r_reset_out;
  assign busy      = r_busy;
  assign state_q   = r_state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: vector table, directed corner sequences and a
// randomized run against a window/schedule reference model.
module tb_sr_latch_driver;

  localparam int D  = 4;
  localparam int PL = 2;
  localparam int QN = D + 3;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic set_in   = 1'b0;
  logic reset_in = 1'b0;
  logic set_out, reset_out, busy, state_q;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_LEN      (PL),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_in   (set_in),
    .reset_in (reset_in),
    .set_out  (set_out),
    .reset_out(reset_out),
    .busy     (busy),
    .state_q  (state_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips when the last D+1 raw samples taken
  // two edges ago all differ from it; pulses come from an output schedule.
  bit       q_s[$];
  bit       q_r[$];
  bit       m_lvl_s, m_lvl_r, m_req_s, m_req_r;
  bit       m_pend_s, m_pend_r, m_state;
  bit [2:0] sched[$];
  bit       m_so, m_ro, m_bz;

  function automatic bit all_equal(input bit q[$], input bit v);
    for (int k = 2; k <= 2 + D; k++)
      if (q[q.size() - 1 - k] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_s.delete();
    q_r.delete();
    for (int i = 0; i < QN; i++) begin
      q_s.push_back(1'b0);
      q_r.push_back(1'b0);
    end
    m_lvl_s = 0; m_lvl_r = 0; m_req_s = 0; m_req_r = 0;
    m_pend_s = 0; m_pend_r = 0; m_state = 0;
    sched.delete();
    m_so = 0; m_ro = 0; m_bz = 0;
  endtask

  task automatic model_step();
    bit ws, wr, ts, tr, old;
    bit [2:0] o;
    if (sched.size() == 0) begin
      ws = m_req_s | m_pend_s;
      wr = m_req_r | m_pend_r;
      ts = ws;
      tr = wr;
`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
      tr = wr & m_state;
      ts = ws & ~m_state;
`endif
      m_pend_s = 0;
      m_pend_r = 0;
      if (tr) begin
        m_state  = 0;
        m_pend_s = ws;
        for (int i = 0; i < PL; i++) sched.push_back(3'b011);
      end else if (ts) begin
        m_state = 1;
        for (int i = 0; i < PL; i++) sched.push_back(3'b101);
      end
      if (tr || ts) begin
        sched.push_back(3'b001);
        sched.push_back(3'b000);
      end
    end else begin
      m_pend_s |= m_req_s;
      m_pend_r |= m_req_r;
    end
    o = (sched.size() != 0) ? sched.pop_front() : 3'b000;
    {m_so, m_ro, m_bz} = o;

    q_s.push_back(set_in);
    q_r.push_back(reset_in);
    while (q_s.size() > QN) void'(q_s.pop_front());
    while (q_r.size() > QN) void'(q_r.pop_front());
    old = m_lvl_s;
    if (all_equal(q_s, !m_lvl_s)) m_lvl_s = !m_lvl_s;
    m_req_s = m_lvl_s & !old;
    old = m_lvl_r;
    if (all_equal(q_r, !m_lvl_r)) m_lvl_r = !m_lvl_r;
    m_req_r = m_lvl_r & !old;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("mdl_set_out", set_out, m_so);
      check("mdl_reset_out", reset_out, m_ro);
      check("mdl_busy", busy, m_bz);
      check("mdl_state_q", state_q, m_state);
      check("mdl_exclusive", set_out & reset_out, 0);
    end
  end

  typedef struct {
    bit s; bit r; bit e_so; bit e_ro; bit e_bz; bit e_sq;
  } vec_t;
  vec_t tbl[14];

  task automatic run_seq(input int n, input int s_from, input int s_to,
                         input int r_from, input int r_to,
                         output int so_first, output int so_cnt,
                         output int ro_first, output int ro_cnt,
                         output int bz_cnt, output int both);
    so_first = -1; so_cnt = 0; ro_first = -1; ro_cnt = 0; bz_cnt = 0; both = 0;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      set_in   = (e >= s_from && e <= s_to);
      reset_in = (e >= r_from && e <= r_to);
      @(posedge clk);
      #1;
      if (set_out && so_first < 0) so_first = e;
      if (reset_out && ro_first < 0) ro_first = e;
      so_cnt += int'(set_out);
      ro_cnt += int'(reset_out);
      bz_cnt += int'(busy);
      both   += int'(set_out & reset_out);
    end
  endtask

  initial begin
    int sf, sc, rf, rc, bc, bh;
    int hold_s, hold_r;

    //            s  r  so ro bz sq
    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 0, 1, 1};
    tbl[8]  = '{1, 0, 1, 0, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1};

    repeat (3) @(posedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_in   = i[0];
      reset_in = ~i[0];
      #1 check("reset_hold_outputs", {set_out, reset_out, busy, state_q}, 0);
    end
    @(negedge clk);
    set_in = 0; reset_in = 0; reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 check("idle_after_reset", {set_out, reset_out, busy, state_q}, 0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      set_in   = tbl[i].s;
      reset_in = tbl[i].r;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_set_out", i), set_out, tbl[i].e_so);
      check($sformatf("vec%0d_reset_out", i), reset_out, tbl[i].e_ro);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_bz);
      check($sformatf("vec%0d_state_q", i), state_q, tbl[i].e_sq);
    end
    run_seq(12, 1, 0, 1, 0, sf, sc, rf, rc, bc, bh);

    sc = 0; rc = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      set_in = ((e / 2) % 2) == 0;
      @(posedge clk);
      #1;
      sc += int'(set_out);
      rc += int'(reset_out);
    end
    run_seq(10, 1, 0, 1, 0, sf, bc, rf, bh, bc, bh);
    check("bounce_no_set_pulse", sc, 0);
    check("bounce_no_reset_pulse", rc, 0);
    check("bounce_state_kept", state_q, 1);

`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
    run_seq(16, 0, 15, 1, 0, sf, sc, rf, rc, bc, bh);
    check("skip_no_set_pulse", sc, 0);
    check("skip_busy_low", bc, 0);
    check("skip_state_kept", state_q, 1);
    run_seq(12, 1, 0, 1, 0, sf, sc, rf, rc, bc, bh);
`else
    run_seq(18, 0, 17, 0, 17, sf, sc, rf, rc, bc, bh);
    check("simul_reset_first_edge", rf, 7);
    check("simul_reset_len", rc, PL);
    check("simul_set_first_edge", sf, 11);
    check("simul_set_len", sc, PL);
    check("simul_never_both", bh, 0);
    check("simul_final_state", state_q, 1);
    run_seq(12, 1, 0, 1, 0, sf, sc, rf, rc, bc, bh);

    run_seq(18, 0, 17, 1, 17, sf, sc, rf, rc, bc, bh);
    check("busy_set_first_edge", sf, 7);
    check("busy_set_len", sc, PL);
    check("busy_reset_first_edge", rf, 11);
    check("busy_single_reset_pulse", rc, PL);
    check("busy_never_both", bh, 0);
    check("busy_final_state", state_q, 0);
    run_seq(12, 1, 0, 1, 0, sf, sc, rf, rc, bc, bh);

    run_seq(9, 0, 8, 1, 8, sf, sc, rf, rc, bc, bh);
    check("mid_set_started", sf, 7);
    check("mid_set_high_before_reset", set_out, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_set_out_dropped", set_out, 0);
    check("mid_state_cleared", state_q, 0);
    check("mid_busy_cleared", busy, 0);
    set_in = 0; reset_in = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_seq(20, 1, 0, 1, 0, sf, sc, rf, rc, bc, bh);
    check("mid_no_set_after", sc, 0);
    check("mid_no_pending_reset", rc, 0);
    check("mid_state_after", state_q, 0);
`endif

    hold_s = 0;
    hold_r = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (hold_s == 0) begin
        set_in = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 10);
      end else hold_s--;
      if (hold_r == 0) begin
        reset_in = 1'($urandom_range(0, 1));
        hold_r = $urandom_range(1, 10);
      end else hold_r--;
    end
    @(negedge clk);
    reset = 1'b0; set_in = 0; reset_in = 0;
    repeat (20) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Upstream stage for the SR latch.
- Turns two raw, bouncy, asynchronous push-button inputs (set request, reset request) into clean, mutually exclusive, fixed-width set/reset pulses.
- Those pulses drive the latch's set and reset inputs directly.
- Guarantees the latch never sees set and reset asserted together, and exports a shadow copy of the state the latch should hold.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a debounced level changes. Must be ≥1.
- PULSE_LEN, 2: cycles set_out/reset_out stay high per pulse. Must be ≥1.
- CNT_W, 8: width of the debounce and pulse counters. Must hold max(DEBOUNCE_CYCLES, PULSE_LEN).

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset; clears all state immediately
- set_in  input  1  raw set button, asynchronous to clk
- reset_in  input  1  raw reset button, asynchronous to clk
- set_out  output  1  set pulse to the latch
- reset_out  output  1  reset pulse to the latch
- busy  output  1  high while a pulse or gap is in progress
- state_q  output  1  expected latch output (shadow)

Behaviour:
- Reset values: set_out=0, reset_out=0, busy=0, state_q=0, synchronizers=0, debounced levels=0, pending flags=0, FSM=IDLE.
- Synchronization: each raw input passes through a 2-flop synchronizer.
- Debounce:
  - Per input, a counter increments while the synchronized value differs from the debounced level.
  - The counter clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
- Request generation: a rising edge of a debounced level creates a one-cycle request. Falling edges create nothing.
- Latency: raw input goes high and is stable from edge 0 → debounced level rises at edge 2+DEBOUNCE_CYCLES → set_out/reset_out rises at edge 3+DEBOUNCE_CYCLES.
- FSM states: IDLE, PULSE_SET, PULSE_RST, GAP.
- IDLE:
  - Reset request (current or pending) present → PULSE_RST. Reset has priority.
  - Otherwise, set request (current or pending) present → PULSE_SET.
  - The consumed pending flag clears.
- PULSE_SET:
  - set_out=1 for exactly PULSE_LEN cycles.
  - state_q←1 on entry.
  - Then → GAP.
- PULSE_RST:
  - reset_out=1 for PULSE_LEN cycles.
  - state_q←0 on entry.
  - Then → GAP.
- GAP: exactly one cycle with both outputs low, then → IDLE.
- busy=1 in PULSE_SET, PULSE_RST and GAP.
- Outputs are registered. set_out and reset_out are never both 1 in any cycle.
- Requests arriving while busy:
  - Each sets a one-deep pending flag per direction.
  - Repeat requests of the same direction while pending are absorbed (no queueing).
- Simultaneous set and reset requests in the same cycle:
  - From IDLE: the reset is served first and the set is left pending.
  - While busy: both become pending, and reset is served first.
- Reset asserted mid-pulse: outputs drop in the same cycle (asynchronously) and all pending requests are lost.

Optional Feature:
- Macro: SR_LATCH_DRIVER_SKIP_REDUNDANT_EN.
- Defined:
  - A request matching the current state_q (set while state_q=1, or reset while state_q=0) is dropped in IDLE.
  - No pulse, busy stays 0.
- Undefined: every request produces a pulse regardless of state_q.

Decomposition:
- Package sr_latch_driver_pkg holds:
  - FSM state enum (IDLE, PULSE_SET, PULSE_RST, GAP) in a 2-bit encoding.
  - Default constants for DEBOUNCE_CYCLES and PULSE_LEN.
- Sub-module sr_debounce, instantiated twice:
  - Contains the 2-flop synchronizer, debounce counter and rising-edge request output.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
- The top level contains the FSM, pending flags, pulse counter and state_q.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_LEN=2):
- Reset check: assert reset with inputs toggling → all outputs 0. Release reset with inputs 0 → outputs stay 0 for 20 cycles.
- Clean set: set_in high from edge 0 → set_out high at edges 7–8, low at 9 (GAP), busy low at 10, state_q=1 from edge 7.
- Bounce rejection: set_in toggles every 2 cycles for 20 cycles, then 0 → no pulse and state_q unchanged.
- Simultaneous debounced set and reset: reset_out pulses 2 cycles, one GAP cycle, then set_out pulses 2 cycles; final state_q=1. Never both high in any cycle.
- Request while busy: reset request during PULSE_SET → reset_out starts 1 cycle after GAP ends. A second reset request during the same pulse produces no extra pulse.
- Mid-pulse reset: assert reset in the 2nd cycle of set_out → set_out=0 immediately, state_q=0, no pending pulse after release. With SKIP_REDUNDANT_EN defined, a set request while state_q=1 produces no pulse.
